// File: rtl/branch_predictor_arbiter.sv
// branch_predictor_arbiter
// Shares one two-level branch predictor between two requesters. Lookups are
// granted round-robin and serialized with their resolution, so the outcome of
// the previous branch is always presented next to the next lookup IP.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   req0/1, req_ip0/1            held lookup requests and their branch IPs
//   gnt0/1                       one-cycle grant pulses
//   pred_valid0/1, pred0/1       prediction strobe and held prediction
//   resolve_valid0/1, _taken0/1  actual outcome from each requester
//   timeout0/1                   one-cycle pulse on forced not-taken resolution
//   bp_ip, bp_taken              drive predictor input_ip / input_taken
//   bp_prediction                predictor prediction output
//   lookup_cnt0/1                saturating lookups per requester
//   mispredict_cnt0/1            saturating mispredictions per requester
module branch_predictor_arbiter #(
   parameter int IP_W    = 64,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [IP_W-1:0]  req_ip0,
   input  logic [IP_W-1:0]  req_ip1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             pred_valid0,
   output logic             pred_valid1,
   output logic             pred0,
   output logic             pred1,
   input  logic             resolve_valid0,
   input  logic             resolve_valid1,
   input  logic             resolve_taken0,
   input  logic             resolve_taken1,
   output logic             timeout0,
   output logic             timeout1,
   output logic [IP_W-1:0]  bp_ip,
   output logic             bp_taken,
   input  logic             bp_prediction,
   output logic [CNT_W-1:0] lookup_cnt0,
   output logic [CNT_W-1:0] lookup_cnt1,
   output logic [CNT_W-1:0] mispredict_cnt0,
   output logic [CNT_W-1:0] mispredict_cnt1
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOOKUP   = 2'd1,
      WAIT_RES = 2'd2
   } state_t;

   // Counter only has to reach TIMEOUT-1; the forced resolution fires on that edge.
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t           state_q;
   logic             owner_q;
   logic             last_gnt_q;
   logic             pred_q;
   logic [TMO_W-1:0] tmo_q;
   logic [IP_W-1:0]  bp_ip_q;
   logic             bp_taken_q;
   logic             gnt0_q, gnt1_q;
   logic             pv0_q, pv1_q;
   logic             pred0_q, pred1_q;
   logic             to0_q, to1_q;
   logic [CNT_W-1:0] lc0_q, lc1_q, mc0_q, mc1_q;

   logic             sel_s;
   logic [IP_W-1:0]  sel_ip_s;
   logic             accept_s;
   logic             taken_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // Round-robin winner selection and owner-only resolve muxing
   always_comb begin
      sel_s    = 1'b0;
      sel_ip_s = req_ip0;
      accept_s = 1'b0;
      taken_s  = 1'b0;
      // requester 1 wins when alone, or on a tie when requester 0 was granted last
      if (req1 && (!req0 || !last_gnt_q)) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
      if (sel_s) begin
         sel_ip_s = req_ip1;
      end else begin
         sel_ip_s = req_ip0;
      end
      if (owner_q) begin
         accept_s = resolve_valid1;
         taken_s  = resolve_taken1;
      end else begin
         accept_s = resolve_valid0;
         taken_s  = resolve_taken0;
      end
   end

   // Arbitration FSM with statistics and all registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         pred_q     <= 1'b0;
         tmo_q      <= '0;
         bp_ip_q    <= '0;
         bp_taken_q <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         pv0_q      <= 1'b0;
         pv1_q      <= 1'b0;
         pred0_q    <= 1'b0;
         pred1_q    <= 1'b0;
         to0_q      <= 1'b0;
         to1_q      <= 1'b0;
         lc0_q      <= '0;
         lc1_q      <= '0;
         mc0_q      <= '0;
         mc1_q      <= '0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         pv0_q  <= 1'b0;
         pv1_q  <= 1'b0;
         to0_q  <= 1'b0;
         to1_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  owner_q    <= sel_s;
                  last_gnt_q <= sel_s;
                  bp_ip_q    <= sel_ip_s;
                  if (sel_s) begin
                     gnt1_q <= 1'b1;
                     lc1_q  <= sat_inc(lc1_q);
                  end else begin
                     gnt0_q <= 1'b1;
                     lc0_q  <= sat_inc(lc0_q);
                  end
                  state_q <= LOOKUP;
               end else begin
                  state_q <= IDLE;
               end
            end
            LOOKUP: begin
               // bp_ip has been stable for a full cycle, so the predictor has settled
               pred_q <= bp_prediction;
               if (owner_q) begin
                  pred1_q <= bp_prediction;
                  pv1_q   <= 1'b1;
               end else begin
                  pred0_q <= bp_prediction;
                  pv0_q   <= 1'b1;
               end
               tmo_q   <= '0;
               state_q <= WAIT_RES;
            end
            WAIT_RES: begin
               if (accept_s) begin
                  bp_taken_q <= taken_s;
                  if (taken_s != pred_q) begin
                     if (owner_q) begin
                        mc1_q <= sat_inc(mc1_q);
                     end else begin
                        mc0_q <= sat_inc(mc0_q);
                     end
                  end else begin
                     mc0_q <= mc0_q;
                  end
                  state_q <= IDLE;
               end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                  // forced not-taken resolution
                  bp_taken_q <= 1'b0;
                  if (owner_q) begin
                     to1_q <= 1'b1;
                  end else begin
                     to0_q <= 1'b1;
                  end
                  if (pred_q) begin
                     if (owner_q) begin
                        mc1_q <= sat_inc(mc1_q);
                     end else begin
                        mc0_q <= sat_inc(mc0_q);
                     end
                  end else begin
                     mc0_q <= mc0_q;
                  end
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0            = gnt0_q;
   assign gnt1            = gnt1_q;
   assign pred_valid0     = pv0_q;
   assign pred_valid1     = pv1_q;
   assign pred0           = pred0_q;
   assign pred1           = pred1_q;
   assign timeout0        = to0_q;
   assign timeout1        = to1_q;
   assign bp_ip           = bp_ip_q;
   assign bp_taken        = bp_taken_q;
   assign lookup_cnt0     = lc0_q;
   assign lookup_cnt1     = lc1_q;
   assign mispredict_cnt0 = mc0_q;
   assign mispredict_cnt1 = mc1_q;

endmodule

// File: tb/tb_branch_predictor_arbiter.sv
`timescale 1ns/1ps
module tb_branch_predictor_arbiter;
   localparam int IP_W = 32;
   localparam int CW   = 2;
   localparam int TMO  = 16;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            req0 = 1'b0, req1 = 1'b0;
   logic [IP_W-1:0] req_ip0 = '0, req_ip1 = '0;
   logic            gnt0, gnt1, pred_valid0, pred_valid1, pred0, pred1;
   logic            resolve_valid0 = 1'b0, resolve_valid1 = 1'b0;
   logic            resolve_taken0 = 1'b0, resolve_taken1 = 1'b0;
   logic            timeout0, timeout1;
   logic [IP_W-1:0] bp_ip;
   logic            bp_taken;
   logic            bp_prediction;
   logic [CW-1:0]   lookup_cnt0, lookup_cnt1, mispredict_cnt0, mispredict_cnt1;

   branch_predictor_arbiter #(.IP_W(IP_W), .CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .req_ip0(req_ip0), .req_ip1(req_ip1),
      .gnt0(gnt0), .gnt1(gnt1),
      .pred_valid0(pred_valid0), .pred_valid1(pred_valid1),
      .pred0(pred0), .pred1(pred1),
      .resolve_valid0(resolve_valid0), .resolve_valid1(resolve_valid1),
      .resolve_taken0(resolve_taken0), .resolve_taken1(resolve_taken1),
      .timeout0(timeout0), .timeout1(timeout1),
      .bp_ip(bp_ip), .bp_taken(bp_taken), .bp_prediction(bp_prediction),
      .lookup_cnt0(lookup_cnt0), .lookup_cnt1(lookup_cnt1),
      .mispredict_cnt0(mispredict_cnt0), .mispredict_cnt1(mispredict_cnt1)
   );

   always #5 clk = ~clk;

   // stand-in predictor: predicts taken when the IP has odd parity
   assign bp_prediction = ^bp_ip;

   typedef struct {
      logic            owner;
      logic [IP_W-1:0] ip;
      logic            tk;
      logic            p0, p1;
      logic [CW-1:0]   lc0, lc1, mc0, mc1;
   } exp_t;

   exp_t gq[$];
   exp_t pq[$];
   exp_t tq[$];

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic            m_last;
   logic            m_taken;
   logic            m_pred[2];
   logic [CW-1:0]   m_lc[2];
   logic [CW-1:0]   m_mc[2];
   logic            pend[2];
   logic [IP_W-1:0] pip[2];

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      if (int'(v) < (1 << CW) - 1) return v + 1'b1;
      else return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last = 1'b1; m_taken = 1'b0;
      m_pred[0] = 1'b0; m_pred[1] = 1'b0;
      m_lc[0] = '0; m_lc[1] = '0; m_mc[0] = '0; m_mc[1] = '0;
   endtask

   task automatic reset_check();
      chk("rst_pulses", {gnt1, gnt0, pred_valid1, pred_valid0, pred1, pred0, timeout1, timeout0}, 64'd0);
      chk("rst_bp_ip", bp_ip, 64'd0);
      chk("rst_bp_taken", bp_taken, 64'd0);
      chk("rst_counters", {lookup_cnt0, lookup_cnt1, mispredict_cnt0, mispredict_cnt1}, 64'd0);
   endtask

   task automatic do_reset();
      resolve_valid0 = 1'b0; resolve_valid1 = 1'b0;
      reset_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b1;
      chk("queues_drained", 64'(gq.size() + pq.size() + tq.size()), 64'd0);
      gq.delete(); pq.delete(); tq.delete();
      model_reset();
      reset_check();
   endtask

   task automatic drive_noise(input int own, input bit noise);
      if (own == 0) begin
         resolve_valid1 = noise & 1'($urandom_range(0, 1));
         resolve_taken1 = 1'($urandom_range(0, 1));
      end else begin
         resolve_valid0 = noise & 1'($urandom_range(0, 1));
         resolve_taken0 = 1'($urandom_range(0, 1));
      end
   endtask

   // One lookup: d = resolve delay in WAIT_RES cycles (>= TMO means never resolve)
   task automatic do_txn(input bit add0, input bit add1,
                         input logic [IP_W-1:0] ipa, input logic [IP_W-1:0] ipb,
                         input int d, input bit tk, input bit noise, input bit rst_mid);
      int own; logic p; bit seen; exp_t e;
      if (add0 && !pend[0]) begin pend[0] = 1'b1; pip[0] = ipa; end
      if (add1 && !pend[1]) begin pend[1] = 1'b1; pip[1] = ipb; end
      if (!pend[0] && !pend[1]) return;
      if (pend[0] && pend[1]) own = (m_last == 1'b0) ? 1 : 0;
      else own = pend[1] ? 1 : 0;
      m_last = own[0];
      m_lc[own] = sat(m_lc[own]);
      p = ^pip[own];
      m_pred[own] = p;
      e.owner = own[0]; e.ip = pip[own]; e.tk = m_taken;
      e.p0 = m_pred[0]; e.p1 = m_pred[1];
      e.lc0 = m_lc[0]; e.lc1 = m_lc[1]; e.mc0 = m_mc[0]; e.mc1 = m_mc[1];
      gq.push_back(e);
      pq.push_back(e);
      if (!rst_mid) begin
         if (d >= TMO) begin
            m_taken = 1'b0;
            if (p) m_mc[own] = sat(m_mc[own]);
            e.tk = 1'b0; e.mc0 = m_mc[0]; e.mc1 = m_mc[1];
            tq.push_back(e);
         end else begin
            m_taken = tk;
            if (tk != p) m_mc[own] = sat(m_mc[own]);
         end
      end
      req0 = pend[0]; req1 = pend[1]; req_ip0 = pip[0]; req_ip1 = pip[1];
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         seen = gnt0 | gnt1;
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL gnt_wait: got no grant in 8 cycles, required gnt%0d", own);
         do_reset();
         return;
      end
      if (gnt1) begin pend[1] = 1'b0; req1 = 1'b0; end
      else begin pend[0] = 1'b0; req0 = 1'b0; end
      @(posedge clk); #1;              // first WAIT_RES cycle (pred_valid)
      if (rst_mid) begin
         drive_noise(own, 1'b1);
         @(posedge clk); #1;
         resolve_valid0 = 1'b0; resolve_valid1 = 1'b0;
         reset_n = 1'b0;
         @(posedge clk); #1;
         reset_n = 1'b1;
         model_reset();
         reset_check();
         return;
      end
      for (int k = 0; k < d && k < TMO; k++) begin
         drive_noise(own, noise);
         @(posedge clk); #1;
      end
      resolve_valid0 = 1'b0; resolve_valid1 = 1'b0;
      if (d < TMO) begin
         drive_noise(own, noise);
         if (own == 0) begin resolve_valid0 = 1'b1; resolve_taken0 = tk; end
         else begin resolve_valid1 = 1'b1; resolve_taken1 = tk; end
         @(posedge clk); #1;
         resolve_valid0 = 1'b0; resolve_valid1 = 1'b0;
      end
   endtask

   // Monitor: every output strobe is matched against the next expected record
   always @(negedge clk) begin : mon
      exp_t e;
      if (gnt0 || gnt1) begin
         if (gq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b, required none", gnt0, gnt1);
         end else begin
            e = gq.pop_front();
            chk("gnt_owner", {gnt1, gnt0}, e.owner ? 64'd2 : 64'd1);
            chk("gnt_bp_ip", bp_ip, e.ip);
            chk("gnt_bp_taken", bp_taken, e.tk);
            chk("gnt_lookup_cnt", {lookup_cnt0, lookup_cnt1}, {e.lc0, e.lc1});
            chk("gnt_mispredict_cnt", {mispredict_cnt0, mispredict_cnt1}, {e.mc0, e.mc1});
         end
      end
      if (pred_valid0 || pred_valid1) begin
         if (pq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL pv_unexpected: got pv0=%0b pv1=%0b, required none", pred_valid0, pred_valid1);
         end else begin
            e = pq.pop_front();
            chk("pv_owner", {pred_valid1, pred_valid0}, e.owner ? 64'd2 : 64'd1);
            chk("pv_preds", {pred1, pred0}, {e.p1, e.p0});
            chk("pv_bp_ip", bp_ip, e.ip);
            chk("pv_lookup_cnt", {lookup_cnt0, lookup_cnt1}, {e.lc0, e.lc1});
         end
      end
      if (timeout0 || timeout1) begin
         if (tq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL to_unexpected: got to0=%0b to1=%0b, required none", timeout0, timeout1);
         end else begin
            e = tq.pop_front();
            chk("to_owner", {timeout1, timeout0}, e.owner ? 64'd2 : 64'd1);
            chk("to_bp_taken", bp_taken, e.tk);
            chk("to_mispredict_cnt", {mispredict_cnt0, mispredict_cnt1}, {e.mc0, e.mc1});
         end
      end
   end

   // Run-time bound
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IP_W-1:0] ip_a, ip_b;
      int r, d;
      pend[0] = 1'b0; pend[1] = 1'b0; pip[0] = '0; pip[1] = '0;
      model_reset();
      do_reset();
      // single grant, predictor returns 1 for 0x400
      do_txn(1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b1, 1'b0, 1'b0);
      do_reset();
      // round robin 0,1,0,1 with immediate resolution
      do_txn(1'b1, 1'b1, 32'h10, 32'h20, 0, 1'b1, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0, 1'b0, 1'b0);
      do_txn(1'b0, 1'b1, 32'h0, 32'h50, 0, 1'b0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'h3, 32'h0, 0, 1'b0, 1'b0, 1'b0);
      chk("rr_lookup_cnt", {lookup_cnt0, lookup_cnt1}, {m_lc[0], m_lc[1]});
      // pending 0x3 predicts 0, resolves taken: mispredict, then forwarded with next IP
      do_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'h8, 32'h0, 2, 1'b0, 1'b0, 1'b0);
      // timeout on requester 1 predicting taken
      do_txn(1'b0, 1'b1, 32'h0, 32'h1, TMO, 1'b0, 1'b0, 1'b0);
      // accept in the last WAIT_RES cycle beats the timeout
      do_txn(1'b0, 1'b1, 32'h0, 32'h7, TMO - 1, 1'b0, 1'b1, 1'b0);
      // non-owner resolve ignored, reset in WAIT_RES, then requester 1 served
      do_txn(1'b1, 1'b0, 32'h6, 32'h0, 0, 1'b0, 1'b1, 1'b1);
      do_txn(1'b0, 1'b1, 32'h0, 32'h9, 1, 1'b1, 1'b1, 1'b0);
      // saturation: five mispredicts on requester 0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         ip_a = $urandom;
         do_txn(1'b1, 1'b0, ip_a, 32'h0, i % 3, ~(^ip_a), 1'b0, 1'b0);
      end
      chk("sat_mispredict_cnt0", mispredict_cnt0, m_mc[0]);
      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         ip_a = $urandom; ip_b = $urandom;
         r = $urandom_range(0, 9);
         if (r < 6) d = $urandom_range(0, 3);
         else if (r == 6) d = TMO - 1;
         else if (r == 7) d = TMO;
         else d = $urandom_range(0, TMO - 1);
         do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ip_a, ip_b, d,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (r == 9) && ($urandom_range(0, 3) == 0));
      end
      req0 = 1'b0; req1 = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("end_queues_drained", 64'(gq.size() + pq.size() + tq.size()), 64'd0);
      chk("end_counters", {lookup_cnt0, lookup_cnt1, mispredict_cnt0, mispredict_cnt1},
          {m_lc[0], m_lc[1], m_mc[0], m_mc[1]});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
